// File: rtl/crc8_frame_check.sv
// crc8_frame_check: receive-side CRC-8 frame checker (poly 0x07, init 0x00,
// MSB first, no reflection, no final XOR). The last byte of each frame is the
// transmitter's CRC, so a correct frame leaves a residue of 0x00.
// Optional build macro: CRC8_CHK_PARALLEL_EN folds the eight bit-steps of a
// byte into a single SHIFT cycle; results are identical to the serial engine.
module crc8_frame_check #(
  parameter int unsigned MAX_BYTES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       done,
  output logic       crc_ok,
  output logic       len_err,
  output logic [7:0] residue,
  output logic [7:0] byte_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BYTES);

  state_t     state_q;
  logic [7:0] data_q;
  logic       last_q;
  logic [7:0] residue_q;
  logic [7:0] residue_d;
  logic [7:0] byte_cnt_q;
  logic       new_frame_q;
  logic       in_ready_q;
  logic       done_q;
  logic       crc_ok_q;
  logic       len_err_q;
  logic [7:0] cnt_base;
  logic [7:0] cnt_inc;
  logic       len_base;
  logic       shift_final;
  logic       short_frame;
`ifndef CRC8_CHK_PARALLEL_EN
  logic [2:0] bit_idx_q;
`endif

  // One CRC bit-step: shift left, fold in the polynomial when the feedback is set.
  function automatic logic [7:0] crc_step(input logic [7:0] r, input logic b);
    logic fb;
    fb = r[7] ^ b;
    return {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Next residue for the current SHIFT cycle and whether it finishes the byte.
  always_comb begin
    residue_d = residue_q;
`ifdef CRC8_CHK_PARALLEL_EN
    for (int unsigned i = 0; i < 8; i++) begin
      residue_d = crc_step(residue_d, data_q[3'(7 - i)]);
    end
    shift_final = 1'b1;
`else
    residue_d   = crc_step(residue_q, data_q[bit_idx_q]);
    shift_final = (bit_idx_q == 3'd0);
`endif
  end

  // Frame bookkeeping: the first byte of a frame counts from a cleared state.
  always_comb begin
    cnt_base    = new_frame_q ? '0 : byte_cnt_q;
    len_base    = new_frame_q ? 1'b0 : len_err_q;
    cnt_inc     = (cnt_base == 8'hFF) ? cnt_base : cnt_base + 8'd1;
    short_frame = (byte_cnt_q < 8'd2);
  end

  // Control FSM with registered outputs; clr overrides any accept on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      last_q      <= 1'b0;
      residue_q   <= '0;
      byte_cnt_q  <= '0;
      new_frame_q <= 1'b1;
      in_ready_q  <= 1'b1;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      len_err_q   <= 1'b0;
`ifndef CRC8_CHK_PARALLEL_EN
      bit_idx_q   <= '0;
`endif
    end else if (clr) begin
      state_q     <= IDLE;
      data_q      <= '0;
      last_q      <= 1'b0;
      residue_q   <= '0;
      byte_cnt_q  <= '0;
      new_frame_q <= 1'b1;
      in_ready_q  <= 1'b1;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      len_err_q   <= 1'b0;
`ifndef CRC8_CHK_PARALLEL_EN
      bit_idx_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            data_q      <= in_data;
            last_q      <= in_last;
            byte_cnt_q  <= cnt_inc;
            len_err_q   <= len_base | (cnt_base >= MAX_B);
            new_frame_q <= 1'b0;
            in_ready_q  <= 1'b0;
            state_q     <= SHIFT;
`ifndef CRC8_CHK_PARALLEL_EN
            bit_idx_q   <= 3'd7;
`endif
            if (new_frame_q) begin
              residue_q <= '0;
              crc_ok_q  <= 1'b0;
            end
          end
        end
        SHIFT: begin
          residue_q <= residue_d;
`ifndef CRC8_CHK_PARALLEL_EN
          bit_idx_q <= bit_idx_q - 3'd1;
`endif
          if (shift_final) begin
            if (last_q) begin
              // Result is registered together with the done pulse so it is valid from done onward.
              state_q   <= DONE;
              done_q    <= 1'b1;
              len_err_q <= len_err_q | short_frame;
              crc_ok_q  <= (residue_d == '0) && !len_err_q && !short_frame;
            end else begin
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          new_frame_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign crc_ok   = crc_ok_q;
  assign len_err  = len_err_q;
  assign residue  = residue_q;
  assign byte_cnt = byte_cnt_q;

endmodule
